// File: rtl/carry_look_ahead.sv
// Three-level carry-lookahead adder (bit / 4-bit group / 16-bit super-block)
// with a registered Sum/Cout/out_valid stage and asynchronous active-low reset.
module carry_look_ahead #(
    parameter int OPERAND_SIZE = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPERAND_SIZE-1:0] A,
    input  logic [OPERAND_SIZE-1:0] B,
    input  logic                    Cin,
    input  logic                    in_valid,
    output logic [OPERAND_SIZE-1:0] Sum,
    output logic                    Cout,
    output logic                    out_valid
);

    localparam int NUM_GROUPS = (OPERAND_SIZE + 3) / 4;
    localparam int NUM_SUPERS = (NUM_GROUPS + 3) / 4;
    localparam int PAD_GROUPS = NUM_SUPERS * 4;
    localparam int PAD_WIDTH  = PAD_GROUPS * 4;

    // Carries into positions 0..3 of a 4-wide block, each fully expanded
    // from the block carry-in so no term waits on a neighbouring carry.
    function automatic logic [3:0] carries4(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       cin
    );
        logic [3:0] c;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    function automatic logic block_gen(
        input logic [3:0] g,
        input logic [3:0] p
    );
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    logic [PAD_WIDTH-1:0]  a_pad;
    logic [PAD_WIDTH-1:0]  b_pad;
    logic [PAD_WIDTH-1:0]  bit_g;
    logic [PAD_WIDTH-1:0]  bit_p;
    logic [PAD_WIDTH:0]    bit_c;
    logic [PAD_WIDTH-1:0]  sum_full;
    logic [PAD_GROUPS-1:0] grp_g;
    logic [PAD_GROUPS-1:0] grp_p;
    logic [PAD_GROUPS-1:0] grp_c;
    logic [3:0]            sup_g;
    logic [3:0]            sup_p;
    logic [4:0]            sup_c;

    logic [OPERAND_SIZE-1:0] sum_reg;
    logic                    cout_reg;
    logic                    out_valid_reg;
    logic                    unused_bits;

    assign a_pad = PAD_WIDTH'(A);
    assign b_pad = PAD_WIDTH'(B);
    assign bit_g = a_pad & b_pad;
    assign bit_p = a_pad ^ b_pad;

    genvar gi;
    generate
        for (gi = 0; gi < PAD_GROUPS; gi++) begin : g_group
            assign grp_g[gi]         = block_gen(bit_g[4*gi +: 4], bit_p[4*gi +: 4]);
            assign grp_p[gi]         = &bit_p[4*gi +: 4];
            assign bit_c[4*gi +: 4]  = carries4(bit_g[4*gi +: 4], bit_p[4*gi +: 4], grp_c[gi]);
        end

        // Unused super-block slots generate and propagate nothing.
        for (gi = 0; gi < 4; gi++) begin : g_super
            if (gi < NUM_SUPERS) begin : g_used
                assign sup_g[gi]        = block_gen(grp_g[4*gi +: 4], grp_p[4*gi +: 4]);
                assign sup_p[gi]        = &grp_p[4*gi +: 4];
                assign grp_c[4*gi +: 4] = carries4(grp_g[4*gi +: 4], grp_p[4*gi +: 4], sup_c[gi]);
            end else begin : g_pad
                assign sup_g[gi] = 1'b0;
                assign sup_p[gi] = 1'b0;
            end
        end
    endgenerate

    assign sup_c[3:0]       = carries4(sup_g, sup_p, Cin);
    assign sup_c[4]         = block_gen(sup_g, sup_p) | (&sup_p & Cin);
    assign bit_c[PAD_WIDTH] = sup_c[NUM_SUPERS];
    assign sum_full         = bit_p ^ bit_c[PAD_WIDTH-1:0];

    // Padding bits and spare top-level carries are intentionally left unread.
    assign unused_bits = ^{sum_full, bit_c, sup_c};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                sum_reg  <= sum_full[OPERAND_SIZE-1:0];
                cout_reg <= bit_c[OPERAND_SIZE];
            end
        end
    end

    assign Sum       = sum_reg;
    assign Cout      = cout_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_carry_look_ahead.sv
// Self-checking bench for carry_look_ahead: directed carry/reset cases on a
// 16-bit instance plus scoreboarded random streams on 8/13/16/32-bit instances.
module tb_carry_look_ahead;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [15:0] a16, b16, sum16;
    logic        cin16, iv16, cout16, ov16;
    logic [7:0]  a8, b8, sum8;
    logic        cin8, iv8, cout8, ov8;
    logic [12:0] a13, b13, sum13;
    logic        cin13, iv13, cout13, ov13;
    logic [31:0] a32, b32, sum32;
    logic        cin32, iv32, cout32, ov32;

    logic [16:0] q16[$];
    logic [8:0]  q8[$];
    logic [13:0] q13[$];
    logic [32:0] q32[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    carry_look_ahead #(.OPERAND_SIZE(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .Cin(cin16), .in_valid(iv16),
        .Sum(sum16), .Cout(cout16), .out_valid(ov16));
    carry_look_ahead #(.OPERAND_SIZE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin8), .in_valid(iv8),
        .Sum(sum8), .Cout(cout8), .out_valid(ov8));
    carry_look_ahead #(.OPERAND_SIZE(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .A(a13), .B(b13), .Cin(cin13), .in_valid(iv13),
        .Sum(sum13), .Cout(cout13), .out_valid(ov13));
    carry_look_ahead #(.OPERAND_SIZE(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .A(a32), .B(b32), .Cin(cin32), .in_valid(iv32),
        .Sum(sum32), .Cout(cout32), .out_valid(ov32));

    // One 16-bit transaction: drive on the falling edge, settle 1 ns past the rising edge.
    task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic v);
        @(negedge clk);
        a16 = a; b16 = b; cin16 = c; iv16 = v;
        @(posedge clk);
        #1;
        $display("[%0t] A=%h B=%h Cin=%b in_valid=%b -> Sum=%h Cout=%b out_valid=%b",
                 $time, a, b, c, v, sum16, cout16, ov16);
    endtask

    task automatic test_reset();
        a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; iv16 = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (sum16 !== 16'h0 || cout16 !== 1'b0 || ov16 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: Sum=%h Cout=%b out_valid=%b, required 0000/0/0",
                         sum16, cout16, ov16);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("[%0t] reset release A=FFFF B=0001 -> Sum=%h Cout=%b out_valid=%b",
                 $time, sum16, cout16, ov16);
        checks++;
        if ({cout16, sum16} !== 17'h10000 || ov16 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: Cout/Sum=%b/%h out_valid=%b, required 1/0000/1",
                     cout16, sum16, ov16);
        end
    endtask

    task automatic test_full_carry();
        drive16(16'hFFFF, 16'h0000, 1'b1, 1'b1);
        checks++;
        if ({cout16, sum16} !== 17'h10000 || ov16 !== 1'b1) begin
            errors++;
            $display("FAIL full_carry_ffff: Cout/Sum=%b/%h, required 1/0000", cout16, sum16);
        end
        drive16(16'h7FFF, 16'h0000, 1'b1, 1'b1);
        checks++;
        if ({cout16, sum16} !== 17'h08000 || ov16 !== 1'b1) begin
            errors++;
            $display("FAIL full_carry_7fff: Cout/Sum=%b/%h, required 0/8000", cout16, sum16);
        end
    endtask

    task automatic test_group_boundaries();
        logic [15:0] ta[3];
        logic [15:0] tb[3];
        logic        tc[3];
        logic [16:0] te[3];
        ta = '{16'h000F, 16'h0FFF, 16'h1234};
        tb = '{16'h0001, 16'h0001, 16'h4321};
        tc = '{1'b0, 1'b0, 1'b1};
        te = '{17'h00010, 17'h01000, 17'h05556};
        for (int i = 0; i < 3; i++) begin
            drive16(ta[i], tb[i], tc[i], 1'b1);
            checks++;
            if ({cout16, sum16} !== te[i] || ov16 !== 1'b1) begin
                errors++;
                $display("FAIL group_boundary_%0d: Cout/Sum=%b/%h out_valid=%b, required %b/%h/1",
                         i, cout16, sum16, ov16, te[i][16], te[i][15:0]);
            end
        end
    endtask

    task automatic test_hold_valid();
        drive16(16'd5, 16'd3, 1'b0, 1'b1);
        checks++;
        if ({cout16, sum16} !== 17'd8 || ov16 !== 1'b1) begin
            errors++;
            $display("FAIL hold_load: Cout/Sum=%b/%h out_valid=%b, required 0/0008/1",
                     cout16, sum16, ov16);
        end
        repeat (3) begin
            drive16(16'd9, 16'd9, 1'b0, 1'b0);
            checks++;
            if ({cout16, sum16} !== 17'd8 || ov16 !== 1'b0) begin
                errors++;
                $display("FAIL hold_idle: Cout/Sum=%b/%h out_valid=%b, required 0/0008/0",
                         cout16, sum16, ov16);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e16;
        logic [8:0]  e8;
        logic [13:0] e13;
        logic [32:0] e32;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a16 = 16'($urandom); a8 = 8'($urandom); a13 = 13'($urandom); a32 = $urandom;
            if (i % 8 == 0) begin
                b16 = ~a16; b8 = ~a8; b13 = ~a13; b32 = ~a32;
            end else begin
                b16 = 16'($urandom); b8 = 8'($urandom); b13 = 13'($urandom); b32 = $urandom;
            end
            cin16 = 1'($urandom); cin8 = 1'($urandom); cin13 = 1'($urandom); cin32 = 1'($urandom);
            iv16 = 1'b1; iv8 = 1'b1; iv13 = 1'b1; iv32 = 1'b1;
            q16.push_back({1'b0, a16} + {1'b0, b16} + 17'(cin16));
            q8.push_back({1'b0, a8} + {1'b0, b8} + 9'(cin8));
            q13.push_back({1'b0, a13} + {1'b0, b13} + 14'(cin13));
            q32.push_back({1'b0, a32} + {1'b0, b32} + 33'(cin32));
            @(posedge clk);
            #1;
            $display("[%0t] stream %0d: w16 %h w8 %h w13 %h w32 %h", $time, i,
                     {cout16, sum16}, {cout8, sum8}, {cout13, sum13}, {cout32, sum32});
            checks++;
            if (ov16 !== 1'b1 || q16.size() == 0) begin
                errors++;
                $display("FAIL stream16_valid: out_valid=%b queued=%0d, required 1", ov16, q16.size());
            end else begin
                e16 = q16.pop_front();
                checks++;
                if ({cout16, sum16} !== e16) begin
                    errors++;
                    $display("FAIL stream16_sum: got %h, required %h", {cout16, sum16}, e16);
                end
            end
            checks++;
            if (ov8 !== 1'b1 || q8.size() == 0) begin
                errors++;
                $display("FAIL stream8_valid: out_valid=%b queued=%0d, required 1", ov8, q8.size());
            end else begin
                e8 = q8.pop_front();
                checks++;
                if ({cout8, sum8} !== e8) begin
                    errors++;
                    $display("FAIL stream8_sum: got %h, required %h", {cout8, sum8}, e8);
                end
            end
            checks++;
            if (ov13 !== 1'b1 || q13.size() == 0) begin
                errors++;
                $display("FAIL stream13_valid: out_valid=%b queued=%0d, required 1", ov13, q13.size());
            end else begin
                e13 = q13.pop_front();
                checks++;
                if ({cout13, sum13} !== e13) begin
                    errors++;
                    $display("FAIL stream13_sum: got %h, required %h", {cout13, sum13}, e13);
                end
            end
            checks++;
            if (ov32 !== 1'b1 || q32.size() == 0) begin
                errors++;
                $display("FAIL stream32_valid: out_valid=%b queued=%0d, required 1", ov32, q32.size());
            end else begin
                e32 = q32.pop_front();
                checks++;
                if ({cout32, sum32} !== e32) begin
                    errors++;
                    $display("FAIL stream32_sum: got %h, required %h", {cout32, sum32}, e32);
                end
            end
        end
        @(negedge clk);
        iv16 = 1'b0; iv8 = 1'b0; iv13 = 1'b0; iv32 = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({ov16, ov8, ov13, ov32} !== 4'b0000) begin
            errors++;
            $display("FAIL stream_drain: out_valid 16/8/13/32=%b%b%b%b, required 0000",
                     ov16, ov8, ov13, ov32);
        end
    endtask

    task automatic test_async_reset();
        drive16(16'h1234, 16'h4321, 1'b1, 1'b1);
        checks++;
        if ({cout16, sum16} !== 17'h05556 || ov16 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: Cout/Sum=%b/%h out_valid=%b, required 0/5556/1",
                     cout16, sum16, ov16);
        end
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; iv16 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        $display("[%0t] async reset asserted -> Sum=%h Cout=%b out_valid=%b", $time, sum16, cout16, ov16);
        checks++;
        if (sum16 !== 16'h0 || cout16 !== 1'b0 || ov16 !== 1'b0) begin
            errors++;
            $display("FAIL async_clear: Sum=%h Cout=%b out_valid=%b, required 0000/0/0",
                     sum16, cout16, ov16);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sum16 !== 16'h0 || cout16 !== 1'b0 || ov16 !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: Sum=%h Cout=%b out_valid=%b, required 0000/0/0",
                     sum16, cout16, ov16);
        end
        @(negedge clk);
        iv16 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("[%0t] reset released idle -> Sum=%h Cout=%b out_valid=%b", $time, sum16, cout16, ov16);
        checks++;
        if (sum16 !== 16'h0 || cout16 !== 1'b0 || ov16 !== 1'b0) begin
            errors++;
            $display("FAIL post_release_idle: Sum=%h Cout=%b out_valid=%b, required 0000/0/0",
                     sum16, cout16, ov16);
        end
        drive16(16'h0001, 16'h0001, 1'b0, 1'b1);
        checks++;
        if ({cout16, sum16} !== 17'h00002 || ov16 !== 1'b1) begin
            errors++;
            $display("FAIL post_release_add: Cout/Sum=%b/%h out_valid=%b, required 0/0002/1",
                     cout16, sum16, ov16);
        end
    endtask

    initial begin
        a8 = '0; b8 = '0; cin8 = 1'b0; iv8 = 1'b0;
        a13 = '0; b13 = '0; cin13 = 1'b0; iv13 = 1'b0;
        a32 = '0; b32 = '0; cin32 = 1'b0; iv32 = 1'b0;
        test_reset();
        test_full_carry();
        test_group_boundaries();
        test_hold_valid();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete, required completion within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
